fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that supplies the controller's instruction word and the matching PC. It drives a word-aligned instruction-memory read interface, sequences the PC by +4, and redirects on taken branches. It holds its output under a downstream stall using a one-entry skid buffer. It sits between instruction memory and the controller/register-file stage, and is the producer of `IR_in`.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- `NOP_WORD`, 32'hE1A0_0000: instruction word presented on `IR_out` when `ir_valid` = 0 (MOV r0,r0, cond AL).

- `CLOCK_50`  in  1  single clock; all state changes on its rising edge.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `stall`  in  1  downstream not ready; `IR_out`/`PC_out`/`ir_valid` must hold.
- `branch_taken`  in  1  redirect request, already condition-qualified.
- `branch_target`  in  32  redirect address; bits [1:0] ignored (forced 0).
- `imem_req`  out  1  read request.
- `imem_addr`  out  32  word address of the request; bits [1:0] = 0.
- `imem_ack`  in  1  `imem_rdata` is valid for the current `imem_addr` this cycle.
- `imem_rdata`  in  32  instruction word.
- `IR_out`  out  32  instruction to controller (`IR_in`).
- `PC_out`  out  32  address of the instruction in `IR_out`.
- `ir_valid`  out  1  `IR_out` holds a real fetched instruction.

## Operation
- Registers: `fetch_pc`, `IR_out`, `PC_out`, `ir_valid`, skid buffer (`skid_ir`, `skid_pc`), state.
- Reset (`RESET_N` = 0, asynchronous): state = IDLE, `fetch_pc` = `RESET_PC`, `IR_out` = `NOP_WORD`, `PC_out` = 0, `ir_valid` = 0, `imem_req` = 0, skid cleared.
- IDLE: `imem_req` = 0. Goes to FETCH on the first edge after reset release.
- FETCH: `imem_req` = 1, `imem_addr` = `fetch_pc`.
  - `imem_ack` and !`stall`: `IR_out` <= `imem_rdata`, `PC_out` <= `fetch_pc`, `ir_valid` <= 1, `fetch_pc` += 4; stay in FETCH.
  - `imem_ack` and `stall`: `skid_ir` <= `imem_rdata`, `skid_pc` <= `fetch_pc`, `fetch_pc` += 4; go to HOLD. Outputs hold.
  - No `imem_ack`, !`stall`: `ir_valid` <= 0, `IR_out` <= `NOP_WORD`.
  - No `imem_ack`, `stall`: outputs hold.
- HOLD: `imem_req` = 0. When `stall` = 0: `IR_out` <= `skid_ir`, `PC_out` <= `skid_pc`, `ir_valid` <= 1; go to FETCH.
- Branch, in any non-reset state: `fetch_pc` <= {`branch_target`[31:2], 2'b00}; skid contents discarded; any `imem_ack` that cycle is ignored; `IR_out` <= `NOP_WORD`, `ir_valid` <= 0; go to FETCH. The branch flushes outputs even while `stall` = 1.
- Priority: reset > `branch_taken` > `stall` > `imem_ack`.
- Arithmetic: `fetch_pc` + 4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Only one request is outstanding at a time. `imem_addr` may change freely after an ack or on a branch; memory must not return stale data for a previous address.

## Timing
- Reset release to first `imem_req`: 1 cycle (IDLE).
- Zero-wait memory (`imem_ack` in the same cycle as `imem_req`): `ir_valid` rises 1 cycle after `imem_req` rises. Throughput is then one instruction per cycle.
- N-cycle ack delay produces N-1 cycles of `ir_valid` = 0 between instructions.
- Branch at edge k: `imem_addr` = target in cycle k+1; with a zero-wait ack, the target instruction is on `IR_out` after edge k+1.
- Stall release: the skid entry appears on `IR_out` 1 edge after `stall` falls, and `imem_req` returns in the same cycle.
- No instruction is lost or duplicated across any stall/ack combination.

## Test plan
- Reset with `RESET_PC` = 0x100 and a zero-wait memory returning `addr ^ 32'hA5A5_0000` -> `PC_out` sequence 0x100, 0x104, 0x108 on consecutive cycles, each with matching `IR_out` and `ir_valid` = 1.
- Hold `stall` = 1 for 3 cycles while an ack arrives for 0x108 -> `IR_out`/`PC_out` hold 0x104; after release 0x108 is presented once, then 0x10C.
- Assert `branch_taken` with target 0x2003 while `stall` = 1 and HOLD is full -> `ir_valid` = 0, `IR_out` = `NOP_WORD`; next `imem_addr` = 0x2000; the skid instruction is never presented.
- Memory acks every 3rd cycle -> `ir_valid` pattern 1,0,0 with no skipped or repeated PC.
- Set `fetch_pc` to 0xFFFF_FFFC via branch -> the next fetch address is 0x0000_0000.
- Assert `RESET_N` low mid-FETCH with an ack pending -> all outputs take reset values immediately, without waiting for a clock edge; fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port between the fetch stage (master) and memory (slave).
`timescale 1ns/1ps

interface fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC, branch redirect, and a one-entry skid buffer
// that absorbs a returned instruction while the consumer is stalled.
`timescale 1ns/1ps

// state | meaning
// IDLE  | first cycle after reset, no request
// FETCH | request outstanding at fetch_pc
// HOLD  | skid entry valid, waiting for stall to drop
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'hE1A0_0000
) (
    input  logic         CLOCK_50,
    input  logic         RESET_N,
    input  logic         stall,
    input  logic         branch_taken,
    input  logic [31:0]  branch_target,
    fetch_unit_if.master imem,
    output logic [31:0]  IR_out,
    output logic [31:0]  PC_out,
    output logic         ir_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] skid_ir;
    logic [31:0] skid_pc;

    assign imem.req  = (state == FETCH);
    assign imem.addr = fetch_pc;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            IR_out   <= NOP_WORD;
            PC_out   <= '0;
            ir_valid <= 1'b0;
            skid_ir  <= '0;
            skid_pc  <= '0;
        end else if (branch_taken) begin
            // Redirect wins over stall: the pipeline is flushed even while held.
            fetch_pc <= branch_target & 32'hFFFF_FFFC;
            skid_ir  <= '0;
            skid_pc  <= '0;
            IR_out   <= NOP_WORD;
            ir_valid <= 1'b0;
            state    <= FETCH;
        end else begin
            case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    if (stall) begin
                        if (imem.ack) begin
                            skid_ir  <= imem.rdata;
                            skid_pc  <= fetch_pc;
                            fetch_pc <= fetch_pc + 32'd4;
                            state    <= HOLD;
                        end
                    end else if (imem.ack) begin
                        IR_out   <= imem.rdata;
                        PC_out   <= fetch_pc;
                        ir_valid <= 1'b1;
                        fetch_pc <= fetch_pc + 32'd4;
                    end else begin
                        IR_out   <= NOP_WORD;
                        ir_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        IR_out   <= skid_ir;
                        PC_out   <= skid_pc;
                        ir_valid <= 1'b1;
                        state    <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by random stall/branch/ack traffic,
// checked against a transaction-level model with a pending-instruction queue.
`timescale 1ns/1ps

module tb_fetch_unit;
    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam logic [31:0] NOP = 32'hE1A0_0000;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        CLOCK_50 = 1'b0;
    logic        RESET_N = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] IR_out;
    logic [31:0] PC_out;
    logic        ir_valid;

    fetch_unit_if imem();

    fetch_unit #(.RESET_PC(RPC), .NOP_WORD(NOP)) dut (
        .CLOCK_50      (CLOCK_50),
        .RESET_N       (RESET_N),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem          (imem),
        .IR_out        (IR_out),
        .PC_out        (PC_out),
        .ir_valid      (ir_valid)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int tests = 0;
    int fails = 0;

    // Model: fetch has started, next address to fetch, presented output, fetched-not-presented queue.
    bit          m_started;
    logic [31:0] m_next;
    logic [31:0] m_ir;
    logic [31:0] m_pc;
    bit          m_valid;
    logic [31:0] q_ir[$];
    logic [31:0] q_pc[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_started = 1'b0;
        m_next    = RPC;
        m_ir      = NOP;
        m_pc      = '0;
        m_valid   = 1'b0;
        q_ir.delete();
        q_pc.delete();
    endtask

    task automatic step(input bit s, input bit b, input logic [31:0] t, input bit a);
        bit req;
        bit ack;
        req = m_started && (q_ir.size() == 0);
        check("imem_req", 32'(imem.req), 32'(req));
        if (req) check("imem_addr", imem.addr, m_next);

        stall         = s;
        branch_taken  = b;
        branch_target = t;
        imem.ack      = a && imem.req;
        imem.rdata    = imem.addr ^ KEY;
        ack           = a && req;

        if (b) begin
            m_next    = {t[31:2], 2'b00};
            q_ir.delete();
            q_pc.delete();
            m_ir      = NOP;
            m_valid   = 1'b0;
            m_started = 1'b1;
        end else if (!m_started) begin
            m_started = 1'b1;
        end else if (s) begin
            if (ack) begin
                q_ir.push_back(m_next ^ KEY);
                q_pc.push_back(m_next);
                m_next = m_next + 32'd4;
            end
        end else if (q_ir.size() != 0) begin
            m_ir    = q_ir.pop_front();
            m_pc    = q_pc.pop_front();
            m_valid = 1'b1;
        end else if (ack) begin
            m_ir    = m_next ^ KEY;
            m_pc    = m_next;
            m_valid = 1'b1;
            m_next  = m_next + 32'd4;
        end else begin
            m_ir    = NOP;
            m_valid = 1'b0;
        end

        @(posedge CLOCK_50);
        #1;
        check("IR_out", IR_out, m_ir);
        check("PC_out", PC_out, m_pc);
        check("ir_valid", 32'(ir_valid), 32'(m_valid));
        if (ir_valid) check("ir_pc_pair", IR_out, PC_out ^ KEY);
    endtask

    initial begin
        bit          rs;
        bit          rb;
        bit          ra;
        logic [31:0] rt;

        imem.ack   = 1'b0;
        imem.rdata = '0;
        model_reset();
        repeat (2) @(posedge CLOCK_50);
        #1;
        check("rst_IR", IR_out, NOP);
        check("rst_PC", PC_out, 32'h0);
        check("rst_valid", 32'(ir_valid), 32'h0);
        check("rst_req", 32'(imem.req), 32'h0);
        RESET_N = 1'b1;

        // Zero-wait stream from RESET_PC.
        step(0, 0, 0, 1);
        check("idle_no_valid", 32'(ir_valid), 32'h0);
        step(0, 0, 0, 1);
        check("seq_pc0", PC_out, 32'h100);
        step(0, 0, 0, 1);
        check("seq_pc1", PC_out, 32'h104);

        // Three stalled cycles; the ack for 0x108 lands in the skid buffer.
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        check("stall_hold_pc", PC_out, 32'h104);
        step(0, 0, 0, 1);
        check("release_pc", PC_out, 32'h108);
        check("release_req", 32'(imem.req), 32'h1);
        step(0, 0, 0, 1);
        check("after_release_pc", PC_out, 32'h10C);

        // Branch while stalled with the skid buffer full.
        step(1, 0, 0, 1);
        step(1, 1, 32'h2003, 1);
        check("br_flush_valid", 32'(ir_valid), 32'h0);
        check("br_flush_ir", IR_out, NOP);
        check("br_target_addr", imem.addr, 32'h2000);
        step(0, 0, 0, 1);
        check("br_target_pc", PC_out, 32'h2000);

        // Memory acks every third request cycle.
        for (int i = 0; i < 9; i++) step(0, 0, 0, (i % 3) == 2);

        // Address wrap at the top of memory.
        step(0, 1, 32'hFFFF_FFFE, 0);
        step(0, 0, 0, 1);
        check("wrap_last_pc", PC_out, 32'hFFFF_FFFC);
        check("wrap_addr", imem.addr, 32'h0);
        step(0, 0, 0, 1);
        check("wrap_pc", PC_out, 32'h0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            rs = ($urandom_range(0, 9) < 3);
            rb = ($urandom_range(0, 19) == 0);
            ra = ($urandom_range(0, 1) == 1);
            rt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
            step(rs, rb, rt, ra);
        end

        // Asynchronous reset mid-FETCH with an ack pending.
        stall        = 1'b0;
        branch_taken = 1'b0;
        step(0, 0, 0, 1);
        imem.ack   = 1'b1;
        imem.rdata = imem.addr ^ KEY;
        #3;
        RESET_N = 1'b0;
        #1;
        check("arst_IR", IR_out, NOP);
        check("arst_PC", PC_out, 32'h0);
        check("arst_valid", 32'(ir_valid), 32'h0);
        check("arst_req", 32'(imem.req), 32'h0);
        imem.ack = 1'b0;
        @(posedge CLOCK_50);
        #1;
        RESET_N = 1'b1;
        model_reset();
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("restart_pc", PC_out, RPC);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
